// File: rtl/lms_weight_serializer.sv
// Serialises LMS weight vectors word-by-word onto a valid/ready stream.
// One vector streams from the active buffer while a second waits in the pending buffer.
module lms_weight_serializer #(
    parameter int N      = 32,
    parameter int OUT_W  = 20,
    parameter int ITER_W = 16,
    parameter int DROP_W = 8,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        valid_in,
    input  logic [N-1:0][OUT_W-1:0]     data_in,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [OUT_W-1:0]            m_data,
    output logic [IDX_W-1:0]            m_index,
    output logic                        m_last,
    output logic [ITER_W-1:0]           m_iter,
    output logic                        busy,
    output logic                        overflow,
    input  logic                        clr_overflow,
    output logic [DROP_W-1:0]           drop_cnt
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                     state;
    logic [N-1:0][OUT_W-1:0]    active_buf;
    logic [N-1:0][OUT_W-1:0]    pend_buf;
    logic                       pend_full;
    logic [IDX_W-1:0]           idx;
    logic [ITER_W-1:0]          iter_cnt;
    logic [ITER_W-1:0]          act_iter;
    logic [ITER_W-1:0]          pend_iter;

    logic xfer;
    logic last_xfer;
    logic drop;

    always_comb begin
        xfer      = 1'b0;
        last_xfer = 1'b0;
        drop      = 1'b0;
        xfer      = (state == SEND) && m_ready;
        last_xfer = xfer && (idx == IDX_W'(N - 1));
        drop      = (state == SEND) && valid_in && pend_full && !last_xfer;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            active_buf <= '0;
            pend_buf   <= '0;
            pend_full  <= 1'b0;
            idx        <= '0;
            iter_cnt   <= '0;
            act_iter   <= '0;
            pend_iter  <= '0;
            overflow   <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_in) begin
                        active_buf <= data_in;
                        idx        <= '0;
                        act_iter   <= iter_cnt;
                        iter_cnt   <= iter_cnt + 1'b1;
                        state      <= SEND;
                    end
                end
                SEND: begin
                    if (last_xfer) begin
                        // Final word leaves: refill active from pending or straight from data_in, no bubble.
                        if (pend_full) begin
                            active_buf <= pend_buf;
                            act_iter   <= pend_iter;
                            idx        <= '0;
                            if (valid_in) begin
                                pend_buf  <= data_in;
                                pend_iter <= iter_cnt;
                                iter_cnt  <= iter_cnt + 1'b1;
                            end else begin
                                pend_full <= 1'b0;
                            end
                        end else if (valid_in) begin
                            active_buf <= data_in;
                            act_iter   <= iter_cnt;
                            iter_cnt   <= iter_cnt + 1'b1;
                            idx        <= '0;
                        end else begin
                            idx   <= '0;
                            state <= IDLE;
                        end
                    end else begin
                        if (xfer)
                            idx <= idx + 1'b1;
                        if (valid_in && !pend_full) begin
                            pend_buf  <= data_in;
                            pend_iter <= iter_cnt;
                            iter_cnt  <= iter_cnt + 1'b1;
                            pend_full <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            // A drop in the same cycle as a clear restarts the count at one.
            if (drop) begin
                overflow <= 1'b1;
                if (clr_overflow)
                    drop_cnt <= DROP_W'(1);
                else if (drop_cnt != '1)
                    drop_cnt <= drop_cnt + 1'b1;
            end else if (clr_overflow) begin
                overflow <= 1'b0;
                drop_cnt <= '0;
            end
        end
    end

    assign m_valid = (state == SEND);
    assign m_data  = active_buf[idx];
    assign m_index = idx;
    assign m_last  = (idx == IDX_W'(N - 1));
    assign m_iter  = act_iter;
    assign busy    = (state == SEND) || pend_full;

endmodule

// File: tb/tb_lms_weight_serializer.sv
// Scoreboard bench for lms_weight_serializer: accepted vectors queue expected words,
// each presented word is checked against the queue head and popped on transfer.
module tb_lms_weight_serializer;

    localparam int N      = 32;
    localparam int OUT_W  = 20;
    localparam int ITER_W = 16;
    localparam int DROP_W = 8;
    localparam int IDX_W  = $clog2(N);

    typedef logic [N-1:0][OUT_W-1:0] vec_t;
    typedef struct {
        logic [OUT_W-1:0]  data;
        logic [IDX_W-1:0]  idx;
        logic              last;
        logic [ITER_W-1:0] iter;
    } word_t;

    logic              clock;
    logic              reset;
    logic              valid_in;
    vec_t              data_in;
    logic              m_valid;
    logic              m_ready;
    logic [OUT_W-1:0]  m_data;
    logic [IDX_W-1:0]  m_index;
    logic              m_last;
    logic [ITER_W-1:0] m_iter;
    logic              busy;
    logic              overflow;
    logic              clr_overflow;
    logic [DROP_W-1:0] drop_cnt;

    int total;
    int bad;
    int ready_mode;

    word_t             sb_q[$];
    logic [ITER_W-1:0] model_iter;
    logic              model_ovf;
    logic [DROP_W-1:0] model_drop;

    lms_weight_serializer #(
        .N(N), .OUT_W(OUT_W), .ITER_W(ITER_W), .DROP_W(DROP_W)
    ) dut (
        .clock(clock), .reset(reset), .valid_in(valid_in), .data_in(data_in),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_index(m_index),
        .m_last(m_last), .m_iter(m_iter), .busy(busy), .overflow(overflow),
        .clr_overflow(clr_overflow), .drop_cnt(drop_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic vec_t make_vec(input int base, input int step);
        vec_t v;
        for (int i = 0; i < N; i++)
            v[i] = OUT_W'(base + step * i);
        return v;
    endfunction

    task automatic strobe(input vec_t v);
        data_in  = v;
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while ((sb_q.size() != 0 || m_valid) && k < 3000) begin
            tick();
            k++;
        end
        check({tag, "_idle_timeout"}, 64'(k < 3000), 64'd1);
    endtask

    task automatic wait_index(input string tag, input int target);
        int k;
        k = 0;
        while (!(m_valid && int'(m_index) == target) && k < 500) begin
            tick();
            k++;
        end
        check({tag, "_index_timeout"}, 64'(k < 500), 64'd1);
    endtask

    // Downstream ready: 0 = always ready, 1 = random, 2 = stalled.
    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            case (ready_mode)
                1:       m_ready = 1'($urandom_range(0, 1));
                2:       m_ready = 1'b0;
                default: m_ready = 1'b1;
            endcase
        end
    end

    // Monitor + reference model, sampled on the falling edge.
    always @(negedge clock) begin
        word_t w;
        int    vecs;
        logic  do_drop;
        if (!reset) begin
            sb_q.delete();
            model_iter = '0;
            model_ovf  = 1'b0;
            model_drop = '0;
            check("rst_m_valid", 64'(m_valid), 64'd0);
            check("rst_m_data", 64'(m_data), 64'd0);
            check("rst_m_index", 64'(m_index), 64'd0);
            check("rst_m_last", 64'(m_last), 64'd0);
            check("rst_m_iter", 64'(m_iter), 64'd0);
            check("rst_busy", 64'(busy), 64'd0);
            check("rst_overflow", 64'(overflow), 64'd0);
            check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        end else begin
            check("m_valid", 64'(m_valid), 64'(sb_q.size() != 0));
            check("busy", 64'(busy), 64'(sb_q.size() != 0));
            check("overflow", 64'(overflow), 64'(model_ovf));
            check("drop_cnt", 64'(drop_cnt), 64'(model_drop));
            if (sb_q.size() != 0 && m_valid) begin
                w = sb_q[0];
                check("m_data", 64'(m_data), 64'(w.data));
                check("m_index", 64'(m_index), 64'(w.idx));
                check("m_last", 64'(m_last), 64'(w.last));
                check("m_iter", 64'(m_iter), 64'(w.iter));
                if (m_ready)
                    void'(sb_q.pop_front());
            end
            do_drop = 1'b0;
            if (valid_in) begin
                vecs = (sb_q.size() + N - 1) / N;
                if (vecs < 2) begin
                    for (int i = 0; i < N; i++) begin
                        w.data = data_in[i];
                        w.idx  = IDX_W'(i);
                        w.last = (i == N - 1);
                        w.iter = model_iter;
                        sb_q.push_back(w);
                    end
                    model_iter = model_iter + 1'b1;
                end else begin
                    do_drop = 1'b1;
                end
            end
            if (do_drop) begin
                model_ovf = 1'b1;
                if (clr_overflow)
                    model_drop = DROP_W'(1);
                else if (model_drop != '1)
                    model_drop = model_drop + 1'b1;
            end else if (clr_overflow) begin
                model_ovf  = 1'b0;
                model_drop = '0;
            end
        end
    end

    initial begin
        vec_t va, vb, vc;
        logic [ITER_W-1:0] it_before;
        total        = 0;
        bad          = 0;
        ready_mode   = 0;
        reset        = 1'b0;
        valid_in     = 1'b0;
        clr_overflow = 1'b0;
        data_in      = '0;
        repeat (3) tick();
        reset = 1'b1;
        tick();

        // Basic stream: words -16..15.
        strobe(make_vec(-16, 1));
        wait_idle("basic");

        // Random backpressure on the same vector.
        ready_mode = 1;
        strobe(make_vec(-16, 1));
        wait_idle("backpressure");
        ready_mode = 0;
        tick();

        // Back-to-back A, B, C: C is dropped.
        va = make_vec(1000, 3);
        vb = make_vec(-5000, -7);
        vc = make_vec(77, 1);
        data_in = va; valid_in = 1'b1; tick();
        data_in = vb; tick();
        data_in = vc; tick();
        valid_in = 1'b0;
        wait_idle("b2b");
        check("b2b_overflow", 64'(overflow), 64'd1);
        check("b2b_drop_cnt", 64'(drop_cnt), 64'd1);
        clr_overflow = 1'b1; tick(); clr_overflow = 1'b0;
        check("b2b_clr_overflow", 64'(overflow), 64'd0);

        // Strobe on the final-word transfer, pending empty: no bubble.
        strobe(make_vec(200, 11));
        wait_index("bnd", N - 1);
        it_before = m_iter;
        strobe(make_vec(-300, 13));
        check("bnd_no_bubble", 64'(m_valid), 64'd1);
        check("bnd_index0", 64'(m_index), 64'd0);
        check("bnd_iter_inc", 64'(m_iter), 64'(ITER_W'(it_before + 1'b1)));
        wait_idle("bnd");

        // Strobe on the final-word transfer, pending full: accepted, no drop.
        strobe(make_vec(400, 1));
        strobe(make_vec(-400, 2));
        wait_index("bnd2", N - 1);
        strobe(make_vec(5, 5));
        check("bnd2_no_drop", 64'(overflow), 64'd0);
        wait_idle("bnd2");

        // Saturation and clear with the stream stalled.
        ready_mode = 2;
        tick();
        strobe(make_vec(1, 1));
        strobe(make_vec(2, 2));
        data_in = make_vec(3, 3);
        valid_in = 1'b1;
        repeat (300) tick();
        valid_in = 1'b0;
        check("sat_drop_cnt", 64'(drop_cnt), 64'd255);
        check("sat_overflow", 64'(overflow), 64'd1);
        clr_overflow = 1'b1; tick(); clr_overflow = 1'b0;
        check("clr_drop_cnt", 64'(drop_cnt), 64'd0);
        check("clr_overflow", 64'(overflow), 64'd0);
        valid_in = 1'b1; clr_overflow = 1'b1; tick();
        valid_in = 1'b0; clr_overflow = 1'b0;
        check("clr_drop_win_cnt", 64'(drop_cnt), 64'd1);
        check("clr_drop_win_ovf", 64'(overflow), 64'd1);
        clr_overflow = 1'b1; tick(); clr_overflow = 1'b0;
        ready_mode = 0;
        wait_idle("sat");

        // Reset mid-stream with pending full, then vector D alone.
        strobe(make_vec(900, 1));
        strobe(make_vec(-900, 1));
        wait_index("rst", 10);
        reset = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        check("rst_release_idle", 64'(m_valid), 64'd0);
        strobe(make_vec(-77, 3));
        check("rst_d_iter", 64'(m_iter), 64'd0);
        wait_idle("rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
